call_stack: RTL and testbench



---
 rtl/call_stack_pkg.sv | 21 ++
 rtl/call_stack_ram.sv | 33 +++
 rtl/call_stack.sv | 210 +++++++++++++++++++++
 tb/tb_call_stack.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack.
//   - OVF_DROP / OVF_CIRC : overflow policy encodings for the OVF_WRAP parameter
//   - op_e                : per-cycle operation decoded from {push request, rtrn}
//   - stack_depth()       : number of entries for a given pointer width
package call_stack_pkg;

  localparam bit OVF_DROP = 1'b0;
  localparam bit OVF_CIRC = 1'b1;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  function automatic int unsigned stack_depth(input int unsigned aw);
    return 32'(1) << aw;
  endfunction

endpackage

// File: rtl/call_stack_ram.sv
// Stack storage: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module call_stack_ram
  import call_stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int unsigned DEPTH = stack_depth(ADDR_WIDTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are never reset; only the pointer/depth define validity.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack for the fetch path.
// A call pushes i_PC; a return pops and presents PC+RET_OFFSET on o_stack.
// Call and return together replace the top entry (tail call).
// Optional feature macro: CALL_STACK_IRQ_EN (adds i_irq / o_in_irq, tagged entries).
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_PC         : PC of the calling instruction
//   i_call       : push request
//   i_rtrn       : pop request
//   i_irq        : push as interrupt frame (CALL_STACK_IRQ_EN only)
//   o_stack      : registered return address
//   o_depth      : occupied entries 0..DEPTH
//   o_empty      : depth == 0
//   o_full       : depth == DEPTH
//   o_ovf, o_udf : sticky overflow / underflow
//   o_in_irq     : tagged frame present (CALL_STACK_IRQ_EN only)
module call_stack
  import call_stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RET_OFFSET = 1,
  parameter bit          OVF_WRAP   = OVF_DROP
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_PC,
  input  logic                  i_call,
  input  logic                  i_rtrn,
`ifdef CALL_STACK_IRQ_EN
  input  logic                  i_irq,
  output logic                  o_in_irq,
`endif
  output logic [DATA_WIDTH-1:0] o_stack,
  output logic [ADDR_WIDTH:0]   o_depth,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_ovf,
  output logic                  o_udf
);

  localparam int unsigned DEPTH   = stack_depth(ADDR_WIDTH);
  localparam int unsigned CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit          WRAP_EN = (OVF_WRAP == OVF_CIRC);

`ifdef CALL_STACK_IRQ_EN
  typedef struct packed {
    logic                  tag;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;
`else
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;
`endif

  localparam int unsigned EW = $bits(entry_t);

  logic [ADDR_WIDTH-1:0] r_sp;
  logic [CW-1:0]         r_depth;
  logic [DATA_WIDTH-1:0] r_stack;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_req;
  op_e                   w_op;
  entry_t                w_new;
  entry_t                w_rd;
  logic [EW-1:0]         w_rdata;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [DATA_WIDTH-1:0] w_ret;
  logic [ADDR_WIDTH-1:0] w_sp_inc;
  logic [ADDR_WIDTH-1:0] w_sp_dec;

  assign w_full   = (r_depth == DEPTH_C);
  assign w_empty  = (r_depth == '0);
  assign w_sp_inc = r_sp + ADDR_WIDTH'(1);
  assign w_sp_dec = r_sp - ADDR_WIDTH'(1);

`ifdef CALL_STACK_IRQ_EN
  // Interrupt takes priority over call; both are push requests.
  assign w_push_req = i_call | i_irq;
  assign w_new.tag  = i_irq;
  assign w_new.pc   = i_PC;
  // Interrupt frames resume the interrupted instruction itself.
  assign w_ret = w_rd.tag ? w_rd.pc : w_rd.pc + DATA_WIDTH'(RET_OFFSET);
`else
  assign w_push_req = i_call;
  assign w_new.pc   = i_PC;
  assign w_ret      = w_rd.pc + DATA_WIDTH'(RET_OFFSET);
`endif

  assign w_op = op_e'({w_push_req, i_rtrn});
  assign w_rd = w_rdata;

  // Memory port control: which slot is written and which is read this cycle.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_sp;
    w_raddr = w_sp_dec;
    case (w_op)
      OP_PUSH: begin
        w_we = !w_full || WRAP_EN;
        // On a wrapping push the slot at sp holds the oldest entry being lost.
        if (w_full && WRAP_EN) w_raddr = r_sp;
      end
      OP_REPLACE: begin
        w_we = 1'b1;
        if (!w_empty) w_waddr = w_sp_dec;
      end
      default: ;
    endcase
    if (i_rst) w_we = 1'b0;
  end

  call_stack_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (EW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_new),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Pointer, depth, return register and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sp    <= '0;
      r_depth <= '0;
      r_stack <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          if (w_full) begin
            r_ovf <= 1'b1;
            if (WRAP_EN) r_sp <= w_sp_inc;
          end else begin
            r_sp    <= w_sp_inc;
            r_depth <= r_depth + CW'(1);
          end
        end
        OP_POP: begin
          if (w_empty) begin
            r_udf <= 1'b1;
          end else begin
            r_stack <= w_ret;
            r_sp    <= w_sp_dec;
            r_depth <= r_depth - CW'(1);
          end
        end
        OP_REPLACE: begin
          if (w_empty) begin
            // Nothing to return to: flag it and fall back to a plain push.
            r_udf   <= 1'b1;
            r_sp    <= w_sp_inc;
            r_depth <= r_depth + CW'(1);
          end else begin
            r_stack <= w_ret;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALL_STACK_IRQ_EN
  logic [CW-1:0] r_irq_cnt;
  logic          w_irq_inc;
  logic          w_irq_dec;
  logic          w_removes;

  // An entry leaves the stack on a pop, on replace, or when a wrapping push overwrites it.
  always_comb begin
    w_removes = 1'b0;
    case (w_op)
      OP_POP:     w_removes = !w_empty;
      OP_REPLACE: w_removes = !w_empty;
      OP_PUSH:    w_removes = w_full && WRAP_EN;
      default:    w_removes = 1'b0;
    endcase
  end

  assign w_irq_inc = w_we && w_new.tag;
  assign w_irq_dec = w_removes && w_rd.tag;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_irq_cnt <= '0;
    else       r_irq_cnt <= r_irq_cnt + CW'(w_irq_inc) - CW'(w_irq_dec);
  end

  assign o_in_irq = (r_irq_cnt != '0);
`endif

  assign o_stack = r_stack;
  assign o_depth = r_depth;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: a default-size instance driven from a vector table,
// plus two ADDR_WIDTH=2 instances (drop / wrap) for overflow handling.
module tb_call_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        call;
  logic        rtrn;
  logic        irq;

  logic [15:0] d_stack;
  logic [4:0]  d_depth;
  logic        d_empty, d_full, d_ovf, d_udf;
  logic [15:0] p_stack, w_stack;
  logic [2:0]  p_depth, w_depth;
  logic        p_empty, p_full, p_ovf, p_udf;
  logic        w_empty, w_full, w_ovf, w_udf;
`ifdef CALL_STACK_IRQ_EN
  logic        d_in_irq, p_in_irq, w_in_irq;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  call_stack u_d (
    .i_clk(clk), .i_rst(rst), .i_PC(pc), .i_call(call), .i_rtrn(rtrn),
`ifdef CALL_STACK_IRQ_EN
    .i_irq(irq), .o_in_irq(d_in_irq),
`endif
    .o_stack(d_stack), .o_depth(d_depth), .o_empty(d_empty), .o_full(d_full),
    .o_ovf(d_ovf), .o_udf(d_udf)
  );

  call_stack #(.ADDR_WIDTH(2), .OVF_WRAP(1'b0)) u_drop (
    .i_clk(clk), .i_rst(rst), .i_PC(pc), .i_call(call), .i_rtrn(rtrn),
`ifdef CALL_STACK_IRQ_EN
    .i_irq(irq), .o_in_irq(p_in_irq),
`endif
    .o_stack(p_stack), .o_depth(p_depth), .o_empty(p_empty), .o_full(p_full),
    .o_ovf(p_ovf), .o_udf(p_udf)
  );

  call_stack #(.ADDR_WIDTH(2), .OVF_WRAP(1'b1)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_PC(pc), .i_call(call), .i_rtrn(rtrn),
`ifdef CALL_STACK_IRQ_EN
    .i_irq(irq), .o_in_irq(w_in_irq),
`endif
    .o_stack(w_stack), .o_depth(w_depth), .o_empty(w_empty), .o_full(w_full),
    .o_ovf(w_ovf), .o_udf(w_udf)
  );

  typedef struct {
    bit          rst;
    bit          call;
    bit          rtrn;
    logic [15:0] pc;
    logic [15:0] exp_stack;
    int          exp_depth;
    bit          exp_ovf;
    bit          exp_udf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic add(input bit r, input bit c, input bit t, input logic [15:0] p,
                     input logic [15:0] es, input int ed, input bit eo, input bit eu);
    vec_t v;
    v.rst = r; v.call = c; v.rtrn = t; v.pc = p;
    v.exp_stack = es; v.exp_depth = ed; v.exp_ovf = eo; v.exp_udf = eu;
    vecs.push_back(v);
  endtask

  task automatic step(input bit r, input bit c, input bit t, input logic [15:0] p);
    rst = r; call = c; rtrn = t; pc = p;
    @(posedge clk);
    #1;
    rst = 1'b0; call = 1'b0; rtrn = 1'b0; irq = 1'b0;
  endtask

  initial begin
    rst = 1'b1; call = 1'b0; rtrn = 1'b0; irq = 1'b0; pc = '0;

    // rst call rtrn pc  -> stack depth ovf udf
    add(1, 0, 0, 16'h0,  16'h0,  0, 0, 0);
    add(0, 1, 0, 16'd10, 16'h0,  1, 0, 0);
    add(0, 0, 1, 16'h0,  16'd11, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(0, 1, 0, 16'(i * 16), 16'd11, i, 0, 0);
    for (int i = 9; i >= 1; i--) add(0, 0, 1, 16'h0, 16'(i * 16 + 1), i - 1, 0, 0);
    add(0, 1, 0, 16'h20, 16'h11, 1, 0, 0);
    add(0, 1, 1, 16'h40, 16'h21, 1, 0, 0);   // tail-call replace
    add(0, 0, 1, 16'h0,  16'h41, 0, 0, 0);
    add(0, 0, 1, 16'h0,  16'h41, 0, 0, 1);   // pop on empty
    add(0, 0, 0, 16'h0,  16'h41, 0, 0, 1);   // idle: sticky flag holds
    add(0, 1, 1, 16'h70, 16'h41, 1, 0, 1);   // replace on empty becomes a push
    add(0, 0, 1, 16'h0,  16'h71, 0, 0, 1);
    add(0, 1, 0, 16'h5,  16'h71, 1, 0, 1);
    add(0, 1, 0, 16'h6,  16'h71, 2, 0, 1);
    add(1, 1, 0, 16'h7,  16'h0,  0, 0, 0);   // reset wins over call
    add(0, 0, 1, 16'h0,  16'h0,  0, 0, 1);   // old entries are gone

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst, vecs[k].call, vecs[k].rtrn, vecs[k].pc);
      check("stack", k, 32'(d_stack), 32'(vecs[k].exp_stack));
      check("depth", k, 32'(d_depth), 32'(vecs[k].exp_depth));
      check("empty", k, 32'(d_empty), 32'(vecs[k].exp_depth == 0));
      check("full",  k, 32'(d_full),  32'(vecs[k].exp_depth == 16));
      check("ovf",   k, 32'(d_ovf),   32'(vecs[k].exp_ovf));
      check("udf",   k, 32'(d_udf),   32'(vecs[k].exp_udf));
    end

    // Depth-4 stacks: push 1..5 into drop and wrap instances.
    step(1, 0, 0, 16'h0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 16'(i));
      check("drop_depth", i, 32'(p_depth), (i > 4) ? 32'd4 : 32'(i));
      check("wrap_depth", i, 32'(w_depth), (i > 4) ? 32'd4 : 32'(i));
      check("drop_full",  i, 32'(p_full),  32'(i >= 4));
      check("wrap_full",  i, 32'(w_full),  32'(i >= 4));
      check("drop_ovf",   i, 32'(p_ovf),   32'(i == 5));
      check("wrap_ovf",   i, 32'(w_ovf),   32'(i == 5));
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 16'h0);
      check("drop_pop", k, 32'(p_stack), 32'(5 - k));
      check("wrap_pop", k, 32'(w_stack), 32'(6 - k));
      check("drop_pdepth", k, 32'(p_depth), 32'(3 - k));
      check("drop_udf0", k, 32'(p_udf), 32'd0);
    end
    step(0, 0, 1, 16'h0);
    check("drop_udf",   5, 32'(p_udf),   32'd1);
    check("wrap_udf",   5, 32'(w_udf),   32'd1);
    check("drop_hold",  5, 32'(p_stack), 32'd2);
    check("wrap_hold",  5, 32'(w_stack), 32'd3);
    check("drop_empty", 5, 32'(p_empty), 32'd1);
    check("wrap_depth0", 5, 32'(w_depth), 32'd0);

`ifdef CALL_STACK_IRQ_EN
    step(1, 0, 0, 16'h0);
    check("irq_rst", 0, 32'(d_in_irq), 32'd0);
    step(0, 1, 0, 16'h30);
    check("irq_call", 1, 32'(d_in_irq), 32'd0);
    irq = 1'b1;
    step(0, 1, 0, 16'h55);
    check("irq_in", 2, 32'(d_in_irq), 32'd1);
    check("irq_depth", 2, 32'(d_depth), 32'd2);
    step(0, 0, 1, 16'h0);
    check("irq_ret", 3, 32'(d_stack), 32'h55);
    check("irq_out", 3, 32'(d_in_irq), 32'd0);
    step(0, 0, 1, 16'h0);
    check("irq_call_ret", 4, 32'(d_stack), 32'h31);
    check("irq_empty", 4, 32'(d_empty), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
